// File: rtl/oramPkg.sv
// ============================================================================
// Module : oramPkg
// Brief  : Shared ORAM geometry, client request payload and client FSM states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package oramPkg;

    // Block-number width and block size in bytes of the attached ORAM
    localparam int d = 8;
    localparam int a = 2;

    typedef struct packed {
        logic             write;
        logic [d-1:0]     addr;
        logic [8*a-1:0]   wdata;
    } oram_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } client_state_e;

endpackage

`default_nettype wire

// File: rtl/oram_req_fifo.sv
// ============================================================================
// Module : oram_req_fifo
// Brief  : Request FIFO with wrap-bit pointers; push and pop on the same edge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oram_req_fifo
    import oramPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  oram_req_t wdata,
    output oram_req_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    oram_req_t   r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

    // Wrap bits differ with equal index: writer is a full lap ahead
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/oram_client.sv
// ============================================================================
// Module : oram_client
// Brief  : Core-side ORAM initiator: queues commands, issues one at a time,
//          returns one response per command. ORAM_CLIENT_TIMEOUT_EN adds a
//          completion timeout reported on rsp_error.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oram_client
    import oramPkg::*;
#(
    parameter int ADDR_W      = d,
    parameter int DATA_W      = 8*a,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output logic [ADDR_W-1:0] oram_block_num,
    output logic [DATA_W-1:0] oram_wvalue,
    output logic              oram_rw,
    output logic              oram_input_ready,
    input  logic [DATA_W-1:0] oram_rvalue,
    input  logic              oram_output_rdy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    client_state_e     r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [ADDR_W-1:0] w_blk_n;
    logic [DATA_W-1:0] w_wv_n, w_rdata_n;
    logic              w_rw_n, w_ir_n, w_rv_n, w_rwr_n;
    logic              w_push, w_pop, w_full, w_empty;
    oram_req_t         w_req, w_head;

    assign w_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign w_push = req_valid && !w_full;

    oram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_req),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef ORAM_CLIENT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYC);
    logic r_err, w_err_n;
    assign rsp_error = r_err;
`else
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            oram_block_num   <= '0;
            oram_wvalue      <= '0;
            oram_rw          <= 1'b0;
            oram_input_ready <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_write        <= 1'b0;
            rsp_rdata        <= '0;
`ifdef ORAM_CLIENT_TIMEOUT_EN
            r_err            <= 1'b0;
`endif
        end else begin
            r_state          <= w_state_n;
            r_cnt            <= w_cnt_n;
            oram_block_num   <= w_blk_n;
            oram_wvalue      <= w_wv_n;
            oram_rw          <= w_rw_n;
            oram_input_ready <= w_ir_n;
            rsp_valid        <= w_rv_n;
            rsp_write        <= w_rwr_n;
            rsp_rdata        <= w_rdata_n;
`ifdef ORAM_CLIENT_TIMEOUT_EN
            r_err            <= w_err_n;
`endif
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_blk_n   = oram_block_num;
        w_wv_n    = oram_wvalue;
        w_rw_n    = oram_rw;
        w_ir_n    = 1'b0;
        w_rv_n    = rsp_valid;
        w_rwr_n   = rsp_write;
        w_rdata_n = rsp_rdata;
        w_pop     = 1'b0;
`ifdef ORAM_CLIENT_TIMEOUT_EN
        w_err_n   = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (!w_empty && !rsp_valid) begin
                    w_blk_n   = w_head.addr;
                    w_wv_n    = w_head.wdata;
                    w_rw_n    = w_head.write;
                    w_ir_n    = 1'b1;
                    w_cnt_n   = '0;
                    w_pop     = 1'b1;
                    w_state_n = WAIT;
                end
            end
            WAIT: begin
`ifdef ORAM_CLIENT_TIMEOUT_EN
                w_cnt_n = (r_cnt == c_TIMEOUT) ? r_cnt : r_cnt + 1'b1;
`else
                w_cnt_n = (r_cnt == '0) ? CNT_W'(1) : r_cnt;
`endif
                // output_rdy on the first WAIT edge is still the previous command's
                if (r_cnt != '0 && oram_output_rdy) begin
                    w_rdata_n = oram_rw ? '0 : oram_rvalue;
                    w_rwr_n   = oram_rw;
                    w_rv_n    = 1'b1;
                    w_state_n = RESP;
                end
`ifdef ORAM_CLIENT_TIMEOUT_EN
                else if (r_cnt == c_TIMEOUT) begin
                    w_rdata_n = '0;
                    w_rwr_n   = oram_rw;
                    w_rv_n    = 1'b1;
                    w_err_n   = 1'b1;
                    w_state_n = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    w_rv_n    = 1'b0;
`ifdef ORAM_CLIENT_TIMEOUT_EN
                    w_err_n   = 1'b0;
`endif
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign req_ready = !w_full;
    assign busy      = !w_empty || (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_oram_client.sv
// ============================================================================
// Module : tb_oram_client
// Brief  : Directed bench with ORAM behavioural model and response scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oram_client;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_error, busy;
    logic [15:0] rsp_rdata;
    logic [7:0]  oram_block_num;
    logic [15:0] oram_wvalue;
    logic        oram_rw, oram_input_ready;
    logic [15:0] oram_rvalue;
    logic        oram_output_rdy;

    always #5 clk = ~clk;

    oram_client #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_write        (rsp_write),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .busy             (busy),
        .oram_block_num   (oram_block_num),
        .oram_wvalue      (oram_wvalue),
        .oram_rw          (oram_rw),
        .oram_input_ready (oram_input_ready),
        .oram_rvalue      (oram_rvalue),
        .oram_output_rdy  (oram_output_rdy)
    );

    // ORAM model: sticky output_ready, result one cycle after sampling input_ready
    logic [15:0] mdl_mem [256];
    logic        mdl_rdy  = 1'b1;
    logic [15:0] mdl_rval = 16'hBEEF;
    logic [15:0] mdl_pend = 16'h0;
    logic        mdl_busy = 1'b0;
    int          mdl_cnt  = 0;
    logic        mdl_delay = 1'b0;
    logic        mdl_hang  = 1'b0;
    int          n_pulses  = 0;

    assign oram_output_rdy = mdl_rdy;
    assign oram_rvalue     = mdl_rval;

    always @(posedge clk) begin
        if (oram_input_ready) begin
            n_pulses <= n_pulses + 1;
            mdl_rdy  <= 1'b0;
            mdl_rval <= 16'hDEAD;
            mdl_busy <= !mdl_hang;
            mdl_cnt  <= mdl_delay ? 6 : 1;
            mdl_pend <= mdl_mem[oram_block_num];
            if (oram_rw) mdl_mem[oram_block_num] <= oram_wvalue;
        end else if (mdl_busy) begin
            if (mdl_cnt == 1) begin
                mdl_rdy  <= 1'b1;
                mdl_rval <= mdl_pend;
                mdl_busy <= 1'b0;
            end
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    // Scoreboard entries: {error, write, rdata}
    logic [17:0] exp_q [$];
    logic [15:0] shadow [256];
    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;
    int n_drop   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            chk("rsp_unexpected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) chk("rsp_data", {14'd0, rsp_error, rsp_write, rsp_rdata}, {14'd0, exp_q.pop_front()});
        end
    end

    // Called at posedge+1; returns at posedge+1 after the push edge
    task automatic send(input logic w, input logic [7:0] ad, input logic [15:0] dt, input logic err);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = ad; req_wdata = dt;
        exp_q.push_back({err, w, (w || err) ? 16'h0 : shadow[ad]});
        if (w) shadow[ad] = dt;
        n_sent++;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_wait", {31'd0, (n < 500)}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_input_ready", {31'd0, oram_input_ready}, 32'd0);
        chk("rst_rsp_fields", {15'd0, rsp_error, rsp_write, rsp_rdata}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write then read back
        send(1'b1, 8'h03, 16'hA5A5, 1'b0);
        send(1'b0, 8'h03, 16'h0000, 1'b0);
        wait_idle();

        // Back-pressure: one response held, four more commands fill the FIFO
        rsp_ready = 1'b0;
        send(1'b1, 8'h40, 16'h1111, 1'b0);
        for (int i = 0; i < 100 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        send(1'b1, 8'h41, 16'h2222, 1'b0);
        send(1'b0, 8'h40, 16'h0000, 1'b0);
        send(1'b0, 8'h41, 16'h0000, 1'b0);
        send(1'b1, 8'h40, 16'h3333, 1'b0);
        chk("fifo_full_ready", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_stable", {14'd0, rsp_error, rsp_write, rsp_rdata}, {14'd0, exp_q[0]});
            chk("hold_no_issue", n_pulses, n_sent - n_drop - 4);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle();

        // Slow completion: stale output_ready must not be taken as completion
        mdl_delay = 1'b1;
        send(1'b1, 8'h10, 16'h1234, 1'b0);
        send(1'b0, 8'h10, 16'h0000, 1'b0);
        wait_idle();
        mdl_delay = 1'b0;

        // Reset while a command is in flight
        send(1'b0, 8'h03, 16'h0000, 1'b0);
        for (int i = 0; i < 20 && !oram_input_ready; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_input_ready", {31'd0, oram_input_ready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("wait_rst_input_ready", {31'd0, oram_input_ready}, 32'd0);
        chk("wait_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("wait_rst_busy", {31'd0, busy}, 32'd0);
        chk("wait_rst_req_ready", {31'd0, req_ready}, 32'd1);
        exp_q.delete();
        n_drop++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(1'b0, 8'h03, 16'h0000, 1'b0);
        wait_idle();

`ifdef ORAM_CLIENT_TIMEOUT_EN
        mdl_hang = 1'b1;
        send(1'b0, 8'h20, 16'h0000, 1'b1);
        wait_idle();
        mdl_hang = 1'b0;
        send(1'b0, 8'h41, 16'h0000, 1'b0);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("input_ready_pulses", n_pulses, n_sent - n_drop);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
